kplic_mctx: RTL and testbench

//  Parametrised multi-target platform-level interrupt controller core, successor to single-target KPLIC.

---
 rtl/kplic_mctx_pkg.sv | 49 ++++
 rtl/kplic_mctx_if.sv | 12 +
 rtl/kplic_mctx_gateway.sv | 57 +++++
 rtl/kplic_mctx.sv | 126 ++++++++++++
 tb/tb_kplic_mctx.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/kplic_mctx_pkg.sv
// Shared constants, register-map decode and access types for the multi-target KPLIC core.
package kplic_mctx_pkg;
  localparam int DATA_W = 32;
  localparam int ID_W   = 5;

  localparam logic [11:0] OFF_PEND = 12'h080;
  localparam logic [11:0] OFF_TYPE = 12'h084;
  localparam logic [11:0] OFF_EN   = 12'h100;
  localparam logic [11:0] OFF_THR  = 12'h200;

  typedef enum logic [2:0] {
    RG_NONE, RG_PRIO, RG_PEND, RG_TYPE, RG_EN, RG_THR, RG_CLAIM
  } reg_kind_e;

  typedef struct packed {
    reg_kind_e       kind;
    logic [ID_W-1:0] src;   // source ID for priority regs
    logic [2:0]      tgt;   // target context for enable/threshold/claim
  } reg_dec_t;

  // Map a byte address onto a register kind; anything outside the live map is RG_NONE.
  function automatic reg_dec_t reg_decode(input logic [11:0] a, input int num_src,
                                          input int num_tgt);
    reg_dec_t d;
    d.kind = RG_NONE;
    d.src  = a[6:2];
    d.tgt  = '0;
    if (a[1:0] == 2'b00) begin
      if (a[11:7] == 5'd0) begin
        if (a[6:2] != 5'd0 && int'(a[6:2]) <= num_src) d.kind = RG_PRIO;
      end else if (a == OFF_PEND) begin
        d.kind = RG_PEND;
      end else if (a == OFF_TYPE) begin
        d.kind = RG_TYPE;
      end else if (a[11:8] == OFF_EN[11:8]) begin
        if (int'(a[7:2]) < num_tgt) begin
          d.kind = RG_EN;
          d.tgt  = a[4:2];
        end
      end else if (a[11:8] == OFF_THR[11:8]) begin
        if (int'(a[7:3]) < num_tgt) begin
          d.kind = a[2] ? RG_CLAIM : RG_THR;
          d.tgt  = a[5:3];
        end
      end
    end
    return d;
  endfunction
endpackage

// File: rtl/kplic_mctx_if.sv
// Register bus between the bus bridge (master) and the KPLIC core (slave).
interface kplic_mctx_if;
  import kplic_mctx_pkg::*;
  logic              valid_reg_access;
  logic              rd_wr;
  logic [11:0]       addr;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;

  modport master (output valid_reg_access, rd_wr, addr, write_data, input read_data);
  modport slave  (input valid_reg_access, rd_wr, addr, write_data, output read_data);
endinterface

// File: rtl/kplic_mctx_gateway.sv
// One interrupt source: input synchroniser, level/edge gateway, pending and in-service bits.
module kplic_mctx_gateway #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_ext,
  input  logic i_edge,      // 1 = edge triggered, 0 = level
  input  logic i_claim,
  input  logic i_complete,
  output logic o_pend,
  output logic o_insvc
);
  logic w_in, w_evt, w_take;
  logic r_prev, r_eflag, r_pend, r_insvc;

  generate
    if (SYNC_STAGES == 0) begin : g_bypass
      assign w_in = i_ext;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] r_sync;
      // Shift the raw input through the synchroniser chain
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_sync <= '0;
        else begin
          r_sync[0] <= i_ext;
          for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
        end
      end
      assign w_in = r_sync[SYNC_STAGES-1];
    end
  endgenerate

  // A fresh rising edge or a held one; only one extra edge is ever remembered.
  assign w_evt  = (w_in & ~r_prev) | r_eflag;
  // A claim in the same cycle wins: the level stays blocked by in_service, the edge stays held.
  assign w_take = i_edge ? (w_evt & ~r_pend & ~r_insvc & ~i_claim)
                         : (w_in & ~r_insvc & ~i_claim);

  // Gateway state: edge history, held edge, pending and in-service
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev  <= 1'b0;
      r_eflag <= 1'b0;
      r_pend  <= 1'b0;
      r_insvc <= 1'b0;
    end else begin
      r_prev  <= w_in;
      r_eflag <= i_edge & w_evt & ~w_take;
      r_pend  <= (r_pend & ~i_claim) | w_take;
      r_insvc <= (r_insvc & ~i_complete) | i_claim;
    end
  end

  assign o_pend  = r_pend;
  assign o_insvc = r_insvc;
endmodule

// File: rtl/kplic_mctx.sv
// Multi-target PLIC core: per-source gateways, per-target enable/threshold and a
// registered max-priority arbiter feeding claim/complete and target_int.
module kplic_mctx
  import kplic_mctx_pkg::*;
#(
  parameter int NUM_SRC     = 31,
  parameter int NUM_TGT     = 2,
  parameter int PRIO_W      = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic               kplic_clk,
  input  logic               kplic_rstn,
  input  logic [NUM_SRC-1:0] external_int,
  kplic_mctx_if.slave        bus,
  output logic [NUM_TGT-1:0] target_int
);
  logic [NUM_SRC:1][PRIO_W-1:0]  r_prio;
  logic [NUM_SRC:1]              r_type;
  logic [NUM_TGT-1:0][NUM_SRC:1] r_en;
  logic [NUM_TGT-1:0][PRIO_W-1:0] r_thr;
  logic [NUM_TGT-1:0][ID_W-1:0]  r_best, w_best;
  logic [NUM_TGT-1:0][PRIO_W-1:0] w_bprio;
  logic [NUM_SRC:1]              w_pend, w_insvc, w_claim, w_cmpl;
  reg_dec_t                      w_dec;
  logic                          w_rd, w_wr;

  assign w_dec = reg_decode(bus.addr, NUM_SRC, NUM_TGT);
  assign w_rd  = bus.valid_reg_access & ~bus.rd_wr;
  assign w_wr  = bus.valid_reg_access &  bus.rd_wr;

  for (genvar i = 1; i <= NUM_SRC; i++) begin : g_gw
    kplic_mctx_gateway #(.SYNC_STAGES(SYNC_STAGES)) u_gw (
      .i_clk      (kplic_clk),
      .i_rst_n    (kplic_rstn),
      .i_ext      (external_int[i-1]),
      .i_edge     (r_type[i]),
      .i_claim    (w_claim[i]),
      .i_complete (w_cmpl[i]),
      .o_pend     (w_pend[i]),
      .o_insvc    (w_insvc[i])
    );
  end

  // Claim takes the registered winner; complete needs in_service and the target's enable
  always_comb begin
    w_claim = '0;
    w_cmpl  = '0;
    for (int t = 0; t < NUM_TGT; t++) begin
      if (w_dec.kind == RG_CLAIM && w_dec.tgt == 3'(t)) begin
        for (int i = 1; i <= NUM_SRC; i++) begin
          if (w_rd && r_best[t] == ID_W'(i)) w_claim[i] = 1'b1;
          if (w_wr && bus.write_data[ID_W-1:0] == ID_W'(i) && w_insvc[i] && r_en[t][i])
            w_cmpl[i] = 1'b1;
        end
      end
    end
  end

  // Ascending scan with strict compare: highest priority wins, ties keep the lowest ID
  always_comb begin
    w_best  = '0;
    w_bprio = '0;
    for (int t = 0; t < NUM_TGT; t++) begin
      for (int i = 1; i <= NUM_SRC; i++) begin
        if (w_pend[i] && r_en[t][i] && r_prio[i] > w_bprio[t]) begin
          w_best[t]  = ID_W'(i);
          w_bprio[t] = r_prio[i];
        end
      end
    end
  end

  // Register the winner and the notification in the same stage
  always_ff @(posedge kplic_clk or negedge kplic_rstn) begin
    if (!kplic_rstn) begin
      r_best     <= '0;
      target_int <= '0;
    end else begin
      for (int t = 0; t < NUM_TGT; t++) begin
        r_best[t]     <= w_best[t];
        target_int[t] <= (w_best[t] != '0) && (w_bprio[t] > r_thr[t]);
      end
    end
  end

  // Configuration register writes
  always_ff @(posedge kplic_clk or negedge kplic_rstn) begin
    if (!kplic_rstn) begin
      r_prio <= '0;
      r_type <= '0;
      r_en   <= '0;
      r_thr  <= '0;
    end else if (w_wr) begin
      case (w_dec.kind)
        RG_PRIO: for (int i = 1; i <= NUM_SRC; i++)
                   if (w_dec.src == ID_W'(i)) r_prio[i] <= bus.write_data[PRIO_W-1:0];
        RG_TYPE: r_type <= bus.write_data[NUM_SRC:1];
        RG_EN:   for (int t = 0; t < NUM_TGT; t++)
                   if (w_dec.tgt == 3'(t)) r_en[t] <= bus.write_data[NUM_SRC:1];
        RG_THR:  for (int t = 0; t < NUM_TGT; t++)
                   if (w_dec.tgt == 3'(t)) r_thr[t] <= bus.write_data[PRIO_W-1:0];
        default: ;
      endcase
    end
  end

  // Combinational read mux; zero when idle, writing, or unmapped
  always_comb begin
    bus.read_data = '0;
    if (w_rd) begin
      case (w_dec.kind)
        RG_PRIO:  for (int i = 1; i <= NUM_SRC; i++)
                    if (w_dec.src == ID_W'(i)) bus.read_data = DATA_W'(r_prio[i]);
        RG_PEND:  bus.read_data = DATA_W'({w_pend, 1'b0});
        RG_TYPE:  bus.read_data = DATA_W'({r_type, 1'b0});
        RG_EN:    for (int t = 0; t < NUM_TGT; t++)
                    if (w_dec.tgt == 3'(t)) bus.read_data = DATA_W'({r_en[t], 1'b0});
        RG_THR:   for (int t = 0; t < NUM_TGT; t++)
                    if (w_dec.tgt == 3'(t)) bus.read_data = DATA_W'(r_thr[t]);
        RG_CLAIM: for (int t = 0; t < NUM_TGT; t++)
                    if (w_dec.tgt == 3'(t)) bus.read_data = DATA_W'(r_best[t]);
        default:  ;
      endcase
    end
  end
endmodule

// File: tb/tb_kplic_mctx.sv
// Scoreboard bench for kplic_mctx: directed scenarios plus randomized traffic against a
// transaction-level model of the gateway/arbiter rules.
module tb_kplic_mctx;
  localparam int NS = 31, NT = 2, PW = 3, SS = 2;
  localparam logic [31:0] SRC_MASK = 32'hFFFF_FFFE;

  logic          clk  = 1'b0;
  logic          rstn = 1'b0;
  logic [NS-1:0] ext  = '0;
  logic [NT-1:0] tint;

  kplic_mctx_if bus();

  kplic_mctx #(.NUM_SRC(NS), .NUM_TGT(NT), .PRIO_W(PW), .SYNC_STAGES(SS)) dut (
    .kplic_clk(clk), .kplic_rstn(rstn), .external_int(ext), .bus(bus), .target_int(tint));

  always #5 clk = ~clk;

  typedef struct { logic [11:0] a; logic [31:0] d; } rexp_t;
  rexp_t         rd_q[$];
  logic [NT-1:0] tint_q[$];
  logic          tchk = 1'b0;
  int            vectors = 0, miscompares = 0;
  rexp_t         mon_e;
  logic [NT-1:0] mon_t;

  // Model: bitmaps indexed by source ID
  int          m_prio[NS+1];
  logic [31:0] m_type, m_pend, m_insvc, m_held, m_lin;
  logic [31:0] m_en[NT];
  int          m_thr[NT];

  function automatic void m_reset();
    for (int i = 0; i <= NS; i++) m_prio[i] = 0;
    m_type = '0; m_pend = '0; m_insvc = '0; m_held = '0; m_lin = '0;
    for (int t = 0; t < NT; t++) begin m_en[t] = '0; m_thr[t] = 0; end
  endfunction

  function automatic int m_best(int t);
    int b = 0, bp = 0;
    for (int i = 1; i <= NS; i++)
      if (m_pend[i] && m_en[t][i] && m_prio[i] > bp) begin b = i; bp = m_prio[i]; end
    return b;
  endfunction

  function automatic logic [NT-1:0] m_tint();
    logic [NT-1:0] r = '0;
    for (int t = 0; t < NT; t++) begin
      int b = m_best(t);
      r[t] = (b != 0) && (m_prio[b] > m_thr[t]);
    end
    return r;
  endfunction

  // Quiescent gateway rules once inputs have propagated
  function automatic void m_settle();
    for (int i = 1; i <= NS; i++) begin
      if (!m_type[i]) begin
        m_held[i] = 1'b0;
        if (m_lin[i] && !m_insvc[i]) m_pend[i] = 1'b1;
      end else if (m_held[i] && !m_pend[i] && !m_insvc[i]) begin
        m_pend[i] = 1'b1; m_held[i] = 1'b0;
      end
    end
  endfunction

  // Monitor: compare every bus read and every requested target_int sample
  initial forever begin
    @(negedge clk);
    if (bus.valid_reg_access && !bus.rd_wr) begin
      vectors++;
      if (rd_q.size() == 0) begin
        miscompares++;
        $display("FAIL rd_unexpected addr=%h got=%h", bus.addr, bus.read_data);
      end else begin
        mon_e = rd_q.pop_front();
        if (bus.read_data !== mon_e.d) begin
          miscompares++;
          $display("FAIL read addr=%h got=%h exp=%h", mon_e.a, bus.read_data, mon_e.d);
        end
      end
    end
    if (tchk) begin
      vectors++;
      if (tint_q.size() == 0) begin
        miscompares++;
        $display("FAIL tint_unexpected got=%b", tint);
      end else begin
        mon_t = tint_q.pop_front();
        if (tint !== mon_t) begin
          miscompares++;
          $display("FAIL target_int got=%b exp=%b at %0t", tint, mon_t, $time);
        end
      end
    end
  end

  task automatic go(); @(posedge clk); #1; endtask
  task automatic idle(int n); repeat (n) go(); endtask

  task automatic bus_wr(logic [11:0] a, logic [31:0] d);
    go();
    bus.valid_reg_access = 1'b1; bus.rd_wr = 1'b1; bus.addr = a; bus.write_data = d;
    go();
    bus.valid_reg_access = 1'b0; bus.rd_wr = 1'b0;
  endtask

  task automatic bus_rd(logic [11:0] a, logic [31:0] e);
    go();
    bus.valid_reg_access = 1'b1; bus.rd_wr = 1'b0; bus.addr = a;
    rd_q.push_back('{a, e});
    go();
    bus.valid_reg_access = 1'b0;
  endtask

  // Call just after a rising edge; sampled at the following falling edge
  task automatic chk_tint_exp(logic [NT-1:0] e);
    tint_q.push_back(e); tchk = 1'b1;
    @(negedge clk); #1 tchk = 1'b0;
  endtask
  task automatic chk_tint(); chk_tint_exp(m_tint()); endtask
  task automatic settle_chk(); idle(6); chk_tint(); endtask

  task automatic set_prio(int s, logic [31:0] d);
    bus_wr(12'(4*s), d); m_prio[s] = int'(d[PW-1:0]);
  endtask
  task automatic set_en(int t, logic [31:0] d);
    bus_wr(12'(12'h100 + 4*t), d); m_en[t] = d & SRC_MASK;
  endtask
  task automatic set_thr(int t, logic [31:0] d);
    bus_wr(12'(12'h200 + 8*t), d); m_thr[t] = int'(d[PW-1:0]);
  endtask
  task automatic set_type(logic [31:0] d);
    bus_wr(12'h084, d); m_type = d & SRC_MASK;
  endtask
  task automatic level(int s, logic v);
    ext[s-1] = v; m_lin[s] = v; idle(4); m_settle();
  endtask
  task automatic pulse(int s);
    ext[s-1] = 1'b1; idle(3); ext[s-1] = 1'b0; idle(4);
    m_held[s] = 1'b1; m_settle();
  endtask
  // exp < 0: expectation comes from the model
  task automatic claim(int t, int exp);
    int id;
    id = m_best(t);
    bus_rd(12'(12'h204 + 8*t), (exp >= 0) ? 32'(exp) : 32'(id));
    if (id != 0) begin m_pend[id] = 1'b0; m_insvc[id] = 1'b1; end
    idle(3);
  endtask
  task automatic complete(int t, int id);
    bus_wr(12'(12'h204 + 8*t), ($urandom & 32'hFFFF_FFE0) | 32'(id));
    if (id >= 1 && id <= NS && m_insvc[id] && m_en[t][id]) m_insvc[id] = 1'b0;
    idle(4); m_settle();
  endtask
  task automatic do_reset();
    go(); rstn = 1'b0; ext = '0; m_reset();
    chk_tint_exp('0);
    go(); rstn = 1'b1;
  endtask

  initial begin
    int s, t, id;
    bus.valid_reg_access = 1'b0; bus.rd_wr = 1'b0; bus.addr = '0; bus.write_data = '0;
    m_reset();
    idle(2);
    chk_tint_exp('0);
    go(); rstn = 1'b1;
    // Reset state
    bus_rd(12'h004, 0); bus_rd(12'h080, 0); bus_rd(12'h084, 0);
    bus_rd(12'h100, 0); bus_rd(12'h200, 0); bus_rd(12'h204, 0); bus_rd(12'h20C, 0);
    // Unmapped addresses read 0 and ignore writes
    bus_wr(12'h108, 32'hFFFF_FFFF); bus_wr(12'h000, 32'h7); bus_wr(12'h210, 32'h7);
    bus_rd(12'h000, 0); bus_rd(12'h088, 0); bus_rd(12'h108, 0); bus_rd(12'h210, 0);
    bus_rd(12'h06E, 0);

    // 1: level latency, claim, refresh
    set_prio(5, 3); set_en(0, 32'h1 << 5); set_thr(0, 0);
    bus_rd(12'h014, 3);
    go(); ext[4] = 1'b1; m_lin[5] = 1'b1;
    idle(3); chk_tint_exp(2'b00);
    go();    chk_tint_exp(2'b01);
    m_settle();
    claim(0, 5);
    bus_rd(12'h080, 0);
    chk_tint_exp(2'b00);
    level(5, 0); complete(0, 5); settle_chk();

    // 2: priority tie -> lowest ID first
    do_reset();
    set_prio(3, 4); set_prio(7, 4); set_en(0, (32'h1 << 3) | (32'h1 << 7));
    level(3, 1); level(7, 1); level(3, 0); level(7, 0); settle_chk();
    claim(0, 3); claim(0, 7); claim(0, 0);

    // 3: threshold gating and next-cycle effect
    do_reset();
    set_prio(2, 2); set_en(1, 32'h1 << 2); set_thr(1, 2);
    level(2, 1); idle(4); chk_tint_exp(2'b00);
    set_thr(1, 1); chk_tint_exp(2'b00);
    go(); chk_tint_exp(2'b10);
    m_thr[1] = 1;

    // 4: edge source holds one extra edge while in service
    do_reset();
    set_type(32'h1 << 9); set_prio(9, 1); set_en(0, 32'h1 << 9);
    pulse(9); settle_chk();
    claim(0, 9); pulse(9); pulse(9); claim(0, 0);
    complete(0, 9); settle_chk();
    claim(0, 9); complete(0, 9); claim(0, 0); settle_chk();

    // 5: shared source across targets, complete needs the target's enable
    do_reset();
    set_prio(4, 2); set_en(0, 32'h1 << 4); set_en(1, 32'h1 << 4);
    level(4, 1); settle_chk();
    claim(0, 4); claim(1, 0);
    set_en(1, 0); complete(1, 4); settle_chk();
    complete(0, 4); settle_chk();
    claim(0, 4);

    // 6: reset mid-operation with pending + in_service
    level(1, 1); set_prio(1, 5); set_en(0, 32'h2);
    go(); rstn = 1'b0; ext = '0; m_reset();
    chk_tint_exp('0);
    bus_rd(12'h010, 0); bus_rd(12'h004, 0); bus_rd(12'h080, 0);
    go(); rstn = 1'b1;
    settle_chk(); bus_rd(12'h080, 0);

    // Randomized episodes
    for (int ep = 0; ep < 4; ep++) begin
      do_reset();
      set_type($urandom);
      for (int i = 1; i <= NS; i++) set_prio(i, $urandom);
      for (int k = 0; k < NT; k++) begin set_en(k, $urandom); set_thr(k, $urandom); end
      repeat (40) begin
        s = $urandom_range(1, NS);
        t = $urandom_range(0, NT-1);
        case ($urandom_range(0, 9))
          0, 1: if (m_type[s]) pulse(s); else level(s, !m_lin[s]);
          2, 3, 4: claim(t, -1);
          5: begin
            id = $urandom_range(0, NS);
            if ($urandom_range(0, 3) != 0)
              for (int i = 1; i <= NS; i++) if (m_insvc[i] && $urandom_range(0, 1) == 1) id = i;
            complete(t, id);
          end
          6: set_prio(s, $urandom);
          7: set_en(t, $urandom);
          8: set_thr(t, $urandom);
          default: begin
            bus_rd(12'h080, m_pend & SRC_MASK);
            bus_rd(12'h084, m_type);
            bus_rd(12'(4*s), 32'(m_prio[s]));
            bus_rd(12'(12'h100 + 4*t), m_en[t]);
            bus_rd(12'(12'h200 + 8*t), 32'(m_thr[t]));
          end
        endcase
        settle_chk();
      end
    end

    idle(4);
    if (rd_q.size() != 0 || tint_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover reads=%0d tint=%0d exp=0", rd_q.size(), tint_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
